// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - decodes SPI config/coordinate bytes into queued paint commands
// SPI_CMD_FIFO_EN selects a FIFO_DEPTH-entry command FIFO; otherwise a single output register.
module spi_cmd_decoder #(
    parameter int COORD_BYTES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     cmd_brush,
    output logic [2:0]               cmd_color,
    output logic [8*COORD_BYTES-1:0] cmd_x,
    output logic [8*COORD_BYTES-1:0] cmd_y,
    output logic                     frame_err,
    output logic                     overflow
);
    localparam int CW    = 8 * COORD_BYTES;
    localparam int CMD_W = 4 + 2 * CW;
    localparam int IW    = (COORD_BYTES > 1) ? $clog2(COORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(COORD_BYTES - 1);

    typedef enum logic {GET_X, GET_Y} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            brush_r;
    logic [2:0]      color_r;
    logic [CW-1:0]   x_acc;
    logic [CW-1:0]   y_acc;

    logic            is_cfg;
    logic            is_coord;
    logic            last_byte;
    logic            push;
    logic            pop;
    logic            accept;
    logic [CW-1:0]   x_next;
    logic [CW-1:0]   y_next;
    logic [CMD_W-1:0] push_word;

    always_comb begin
        is_cfg    = byte_valid && (byte_data[7:5] == 3'b111);
        is_coord  = byte_valid && (byte_data[7:5] != 3'b111);
        last_byte = (idx == LAST_IDX);
        x_next    = CW'({x_acc, byte_data});
        y_next    = CW'({y_acc, byte_data});
        push      = is_coord && (state == GET_Y) && last_byte;
        push_word = {brush_r, color_r, x_acc, y_next};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= GET_X;
            idx       <= '0;
            brush_r   <= 1'b0;
            color_r   <= '0;
            x_acc     <= '0;
            y_acc     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (is_cfg) begin
                brush_r <= byte_data[4];
                color_r <= byte_data[2:0];
                // A config byte inside a coordinate frame aborts it.
                if (state == GET_Y || idx != '0) begin
                    frame_err <= 1'b1;
                    state     <= GET_X;
                    idx       <= '0;
                    x_acc     <= '0;
                    y_acc     <= '0;
                end
            end else if (is_coord) begin
                if (state == GET_X) begin
                    x_acc <= x_next;
                end else begin
                    y_acc <= y_next;
                end
                if (last_byte) begin
                    idx   <= '0;
                    state <= (state == GET_X) ? GET_Y : GET_X;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

`ifdef SPI_CMD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;

    always_comb begin
        pop    = (count != '0) && cmd_ready;
        full   = (count == (AW+1)'(FIFO_DEPTH));
        accept = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign cmd_valid = (count != '0);
    assign {cmd_brush, cmd_color, cmd_x, cmd_y} = mem[rd_ptr];
`else
    logic [CMD_W-1:0] head;
    logic             head_valid;
    logic             unused_depth;

    // Depth is fixed at one slot here.
    assign unused_depth = ^FIFO_DEPTH;

    always_comb begin
        pop    = head_valid && cmd_ready;
        accept = push && (!head_valid || pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head       <= '0;
            head_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                head       <= push_word;
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    assign cmd_valid = head_valid;
    assign {cmd_brush, cmd_color, cmd_x, cmd_y} = head;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - randomized and directed bench for spi_cmd_decoder
module tb_spi_cmd_decoder;
`ifdef SPI_CMD_FIFO_EN
    localparam int MD = 4;
`else
    localparam int MD = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       bv = 1'b0, rdy = 1'b0;
    logic [7:0] bd = '0;
    logic       cv, cb, fe, ov;
    logic [2:0] cc;
    logic [7:0] cx, cy;

    logic        bv2 = 1'b0, rdy2 = 1'b0;
    logic [7:0]  bd2 = '0;
    logic        cv2, cb2, fe2, ov2;
    logic [2:0]  cc2;
    logic [15:0] cx2, cy2;

    spi_cmd_decoder #(.COORD_BYTES(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .byte_valid(bv), .byte_data(bd),
        .cmd_valid(cv), .cmd_ready(rdy), .cmd_brush(cb), .cmd_color(cc),
        .cmd_x(cx), .cmd_y(cy), .frame_err(fe), .overflow(ov));

    spi_cmd_decoder #(.COORD_BYTES(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .byte_valid(bv2), .byte_data(bd2),
        .cmd_valid(cv2), .cmd_ready(rdy2), .cmd_brush(cb2), .cmd_color(cc2),
        .cmd_x(cx2), .cmd_y(cy2), .frame_err(fe2), .overflow(ov2));

    int tests = 0;
    int fails = 0;

    // Reference model of the 1-byte-coordinate instance: a bounded command queue.
    logic [19:0] mq[$];
    logic        m_brush, m_in_y, m_ovf, m_ferr;
    logic [2:0]  m_color;
    logic [7:0]  m_x;

    task automatic model_reset();
        mq.delete();
        m_brush = 0; m_color = 0; m_in_y = 0; m_x = 0; m_ovf = 0; m_ferr = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic pop, push, ferr;
        logic [19:0] w;
        bv = v; bd = d; rdy = r; bv2 = 0; rdy2 = 0;
        pop = r && (mq.size() > 0);
        push = 0; ferr = 0; w = '0;
        if (v) begin
            if (d[7:5] == 3'b111) begin
                ferr = m_in_y; m_in_y = 0; m_brush = d[4]; m_color = d[2:0];
            end else if (!m_in_y) begin
                m_x = d; m_in_y = 1;
            end else begin
                push = 1; w = {m_brush, m_color, m_x, d}; m_in_y = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < MD) mq.push_back(w);
            else m_ovf = 1;
        end
        m_ferr = ferr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step2(input logic v, input logic [7:0] d, input logic r);
        bv2 = v; bd2 = d; rdy2 = r; bv = 0; rdy = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0; bv = 1; bd = 8'hF7; bv2 = 1; bd2 = 8'hF7; rdy = 0; rdy2 = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1; bv = 0; bv2 = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (cv !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", cv); end
        tests++; if (cb !== 1'b0) begin fails++; $display("FAIL reset_brush got %0b want 0", cb); end
        tests++; if (cc !== 3'd0) begin fails++; $display("FAIL reset_color got %0d want 0", cc); end
        tests++; if (cx !== 8'd0 || cy !== 8'd0) begin fails++; $display("FAIL reset_xy got %h/%h want 0/0", cx, cy); end
        tests++; if (fe !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %0b want 0", fe); end
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b want 0", ov); end
        tests++; if (cv2 !== 1'b0 || ov2 !== 1'b0) begin fails++; $display("FAIL reset_dut2 got v=%0b o=%0b want 0 0", cv2, ov2); end
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 8'hE5, 0);
        step(1, 8'h10, 0);
        tests++; if (cv !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %0b want 0", cv); end
        step(1, 8'h20, 0);
        tests++; if (cv !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", cv); end
        tests++; if ({cb, cc, cx, cy} !== {1'b0, 3'd5, 8'h10, 8'h20}) begin
            fails++; $display("FAIL basic_cmd got b=%0b c=%0d x=%h y=%h want b=0 c=5 x=10 y=20", cb, cc, cx, cy); end
        step(0, 8'h00, 0);
        tests++; if (cv !== 1'b1 || {cb, cc, cx, cy} !== {1'b0, 3'd5, 8'h10, 8'h20}) begin
            fails++; $display("FAIL basic_hold got v=%0b x=%h y=%h want v=1 x=10 y=20", cv, cx, cy); end
        step(0, 8'h00, 1);
        tests++; if (cv !== 1'b0) begin fails++; $display("FAIL basic_pop got %0b want 0", cv); end
    endtask

    task automatic test_frame_abort();
        do_reset();
        step(1, 8'h10, 0);
        tests++; if (fe !== 1'b0) begin fails++; $display("FAIL abort_pre got %0b want 0", fe); end
        step(1, 8'hE1, 0);
        tests++; if (fe !== 1'b1) begin fails++; $display("FAIL abort_pulse got %0b want 1", fe); end
        step(1, 8'h20, 0);
        tests++; if (fe !== 1'b0 || cv !== 1'b0) begin fails++; $display("FAIL abort_after got fe=%0b v=%0b want 0 0", fe, cv); end
        step(1, 8'h30, 0);
        tests++; if (cv !== 1'b1 || {cb, cc, cx, cy} !== {1'b0, 3'd1, 8'h20, 8'h30}) begin
            fails++; $display("FAIL abort_cmd got v=%0b c=%0d x=%h y=%h want v=1 c=1 x=20 y=30", cv, cc, cx, cy); end
        step(0, 8'h00, 1);
    endtask

    task automatic test_coord2();
        do_reset();
        step2(1, 8'hF3, 0); step2(1, 8'h01, 0); step2(1, 8'h02, 0); step2(1, 8'h03, 0);
        tests++; if (cv2 !== 1'b0) begin fails++; $display("FAIL c2_early got %0b want 0", cv2); end
        step2(1, 8'h04, 0);
        tests++; if (cv2 !== 1'b1 || {cb2, cc2, cx2, cy2} !== {1'b1, 3'd3, 16'h0102, 16'h0304}) begin
            fails++; $display("FAIL c2_cmd got v=%0b b=%0b c=%0d x=%h y=%h want 1 1 3 0102 0304", cv2, cb2, cc2, cx2, cy2); end
        step2(0, 8'h00, 1);
        step2(1, 8'h05, 0);
        step2(1, 8'hE0, 0);
        tests++; if (fe2 !== 1'b1) begin fails++; $display("FAIL c2_abort got %0b want 1", fe2); end
        step2(1, 8'h0A, 0); step2(1, 8'h0B, 0); step2(1, 8'h0C, 0); step2(1, 8'h0D, 0);
        tests++; if (cv2 !== 1'b1 || {cb2, cc2, cx2, cy2} !== {1'b0, 3'd0, 16'h0A0B, 16'h0C0D}) begin
            fails++; $display("FAIL c2_cmd2 got v=%0b b=%0b c=%0d x=%h y=%h want 1 0 0 0a0b 0c0d", cv2, cb2, cc2, cx2, cy2); end
        step2(0, 8'h00, 1);
    endtask

    task automatic test_overflow();
        logic [19:0] exp_q[$];
        logic [7:0] x, y;
        int n;
        do_reset();
        step(1, 8'hF6, 0);
        for (int i = 0; i <= MD; i++) begin
            x = 8'($urandom_range(0, 223)); y = 8'($urandom_range(0, 223));
            if (i < MD) exp_q.push_back({1'b1, 3'd6, x, y});
            if (i == MD) begin
                tests++; if (ov !== 1'b0) begin fails++; $display("FAIL ovf_early got %0b want 0", ov); end
            end
            step(1, x, 0); step(1, y, 0);
        end
        tests++; if (ov !== 1'b1) begin fails++; $display("FAIL ovf_set got %0b want 1", ov); end
        n = 0;
        for (int i = 0; i < MD + 3; i++) begin
            if (cv === 1'b1) begin
                tests++; if (n >= MD || {cb, cc, cx, cy} !== exp_q[n]) begin
                    fails++; $display("FAIL ovf_drain[%0d] got %h want %h", n, {cb, cc, cx, cy}, (n < MD) ? exp_q[n] : 20'h0); end
                n++;
            end
            step(0, 8'h00, 1);
        end
        tests++; if (n != MD) begin fails++; $display("FAIL ovf_count got %0d want %0d", n, MD); end
        tests++; if (ov !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %0b want 1", ov); end
    endtask

    task automatic test_full_pop_push();
        logic [19:0] exp_q[$];
        logic [7:0] x, y;
        int n;
        do_reset();
        for (int i = 0; i <= MD; i++) begin
            x = 8'($urandom_range(0, 223)); y = 8'($urandom_range(0, 223));
            exp_q.push_back({1'b0, 3'd0, x, y});
            step(1, x, 0);
            step(1, y, i == MD);
        end
        void'(exp_q.pop_front());
        tests++; if (ov !== 1'b0 || cv !== 1'b1) begin fails++; $display("FAIL fpp_flags got o=%0b v=%0b want 0 1", ov, cv); end
        n = 0;
        for (int i = 0; i < MD + 3; i++) begin
            if (cv === 1'b1) begin
                tests++; if (n >= MD || {cb, cc, cx, cy} !== exp_q[n]) begin
                    fails++; $display("FAIL fpp_drain[%0d] got %h want %h", n, {cb, cc, cx, cy}, (n < MD) ? exp_q[n] : 20'h0); end
                n++;
            end
            step(0, 8'h00, 1);
        end
        tests++; if (n != MD) begin fails++; $display("FAIL fpp_count got %0d want %0d", n, MD); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        step(1, 8'hF2, 0);
        step(1, 8'h01, 0); step(1, 8'h02, 0);
        step(1, 8'h03, 0); step(1, 8'h04, 0);
        step(1, 8'h05, 0);
        do_reset();
        tests++; if (cv !== 1'b0 || ov !== 1'b0) begin fails++; $display("FAIL rmid_flags got v=%0b o=%0b want 0 0", cv, ov); end
        step(1, 8'h11, 0); step(1, 8'h22, 0);
        tests++; if (cv !== 1'b1 || {cb, cc, cx, cy} !== {1'b0, 3'd0, 8'h11, 8'h22}) begin
            fails++; $display("FAIL rmid_cmd got v=%0b b=%0b c=%0d x=%h y=%h want 1 0 0 11 22", cv, cb, cc, cx, cy); end
        step(0, 8'h00, 1);
    endtask

    task automatic test_random();
        logic v, r;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(224, 255)) : 8'($urandom_range(0, 223));
            r = ($urandom_range(0, 2) == 0);
            step(v, d, r);
            tests++; if (cv !== (mq.size() > 0)) begin fails++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, cv, mq.size() > 0); end
            if (mq.size() > 0) begin
                tests++; if ({cb, cc, cx, cy} !== mq[0]) begin fails++; $display("FAIL rnd_cmd[%0d] got %h want %h", i, {cb, cc, cx, cy}, mq[0]); end
            end
            tests++; if (fe !== m_ferr) begin fails++; $display("FAIL rnd_ferr[%0d] got %0b want %0b", i, fe, m_ferr); end
            tests++; if (ov !== m_ovf) begin fails++; $display("FAIL rnd_ovf[%0d] got %0b want %0b", i, ov, m_ovf); end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_frame_abort();
        test_coord2();
        test_overflow();
        test_full_pop_push();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
